seqcmp_n: RTL and testbench

Parametrised, multi-cycle magnitude/equality comparator. It latches two WIDTH-bit operands on a start request and walks them MSB-first, one CHUNK-bit slice per clock. It terminates early on the first differing slice and reports the result with a one-cycle done pulse. It generalises the 2-bit combinational equality comparator to arbitrary widths, adds a start/busy/done handshake, and adds an optional greater-than/less-than output, for use where a wide combinational compare would break timing.

---
 rtl/seqcmp_n.sv | 121 ++++++++++++
 tb/tb_seqcmp_n.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqcmp_n.sv
// Multi-cycle MSB-first slice comparator with start/busy/done handshake.
// Define CMP_MAG_EN to build the unsigned greater-than / less-than outputs.
module seqcmp_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             slice_ne;
    logic             accept;
    logic             finish;
    logic             aeqb_q;

    assign slice_a  = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_b  = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_ne = (slice_a != slice_b);

    // start is only honoured outside RUN, so a request while busy is dropped.
    assign accept = (state_q != RUN) && start;
    assign finish = (state_q == RUN) && (slice_ne || (idx_q == '0));

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d receives a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? RUN : IDLE;
            RUN:        state_d = finish ? DONE : RUN;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= LAST_IDX;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            idx_q <= LAST_IDX;
        end else if ((state_q == RUN) && !finish) begin
            idx_q <= idx_q - IDX_W'(1);
        end
    end

    // Results move only on the edge that enters DONE and hold until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aeqb_q <= 1'b0;
        end else if (finish) begin
            aeqb_q <= !slice_ne;
        end
    end

`ifdef CMP_MAG_EN
    logic slice_gt;
    logic agtb_q;
    logic altb_q;

    assign slice_gt = (slice_a > slice_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            agtb_q <= 1'b0;
            altb_q <= 1'b0;
        end else if (finish) begin
            agtb_q <= slice_ne && slice_gt;
            altb_q <= slice_ne && !slice_gt;
        end
    end

    assign agtb = agtb_q;
    assign altb = altb_q;
`else
    assign agtb = 1'b0;
    assign altb = 1'b0;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign aeqb = aeqb_q;

endmodule

// File: tb/tb_seqcmp_n.sv
// Randomised and directed bench for seqcmp_n against a whole-word reference model.
module tb_seqcmp_n;

    localparam int W      = 16;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = W / CHUNK;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         aeqb;
    logic         agtb;
    logic         altb;

    int checks;
    int failures;

    // Last completed result as the model sees it; outputs must hold this between completions.
    logic res_eq;
    logic res_gt;
    logic res_lt;

    seqcmp_n #(.WIDTH(W), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .aeqb  (aeqb),
        .agtb  (agtb),
        .altb  (altb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slices examined: top slice down to and including the first one holding a differing bit.
    function automatic int calc_k(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return NCHUNK - i / CHUNK;
        return NCHUNK;
    endfunction

    function automatic logic mag_gt(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_MAG_EN
        return x > y;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic mag_lt(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_MAG_EN
        return x < y;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_results(input string tag);
        check_bit({tag, " aeqb"}, aeqb, res_eq);
        check_bit({tag, " agtb"}, agtb, res_gt);
        check_bit({tag, " altb"}, altb, res_lt);
    endtask

    // Present a request; the caller guarantees we are away from a rising edge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
    endtask

    // Follows one compare from its accepting edge to the DONE cycle (returns at its negedge).
    // keep_start leaves start high throughout; poke > 0 pulses a conflicting start in that RUN cycle.
    task automatic follow(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit keep_start, input int poke);
        int k;
        k = calc_k(ta, tb_v);
        @(posedge clk);
        #1;
        if (!keep_start) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
        end
        for (int c = 1; c <= k + 1; c++) begin
            @(negedge clk);
            if (c <= k) begin
                check_bit($sformatf("run busy c%0d", c), busy, 1'b1);
                check_bit($sformatf("run done c%0d", c), done, 1'b0);
                check_results("run hold");
                if (poke != 0 && c == poke) begin
                    start = 1'b1;
                    a     = 16'hFFFF;
                    b     = 16'h0000;
                end else if (poke != 0 && c == poke + 1) begin
                    start = 1'b0;
                end
            end else begin
                res_eq = (ta == tb_v);
                res_gt = mag_gt(ta, tb_v);
                res_lt = mag_lt(ta, tb_v);
                check_bit("done pulse", done, 1'b1);
                check_bit("done busy", busy, 1'b0);
                check_results($sformatf("result %h/%h", ta, tb_v));
            end
        end
    endtask

    // One cycle after a non-chained completion: back in IDLE with results held.
    task automatic check_idle();
        start = 1'b0;
        @(negedge clk);
        check_bit("idle busy", busy, 1'b0);
        check_bit("idle done", done, 1'b0);
        check_results("idle hold");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        res_eq = 1'b0;
        res_gt = 1'b0;
        res_lt = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset done", done, 1'b0);
        check_results("reset");
        reset = 1'b0;
        @(negedge clk);
        check_bit("post-reset busy", busy, 1'b0);
    endtask

    task automatic test_directed();
        launch(16'hA5A5, 16'hA5A5);
        follow(16'hA5A5, 16'hA5A5, 1'b0, 0);
        check_idle();
        launch(16'h8000, 16'h0000);
        follow(16'h8000, 16'h0000, 1'b0, 0);
        check_idle();
        launch(16'h0001, 16'h0002);
        follow(16'h0001, 16'h0002, 1'b0, 0);
        check_idle();
    endtask

    task automatic test_start_while_busy();
        launch(16'h1234, 16'h1234);
        follow(16'h1234, 16'h1234, 1'b0, 3);
        check_idle();
    endtask

    task automatic test_reset_abort();
        launch(16'h5A5A, 16'h5A5A);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_bit("pre-abort busy", busy, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        res_eq = 1'b0;
        res_gt = 1'b0;
        res_lt = 1'b0;
        check_bit("abort busy", busy, 1'b0);
        check_bit("abort done", done, 1'b0);
        check_results("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_bit("abort no done", done, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        check_bit("after abort done", done, 1'b0);
        check_bit("after abort busy", busy, 1'b0);
        launch(16'h0003, 16'h0003);
        follow(16'h0003, 16'h0003, 1'b0, 0);
        check_idle();
    endtask

    task automatic test_reset_with_start();
        reset = 1'b1;
        launch(16'hC000, 16'h4000);
        @(negedge clk);
        res_eq = 1'b0;
        res_gt = 1'b0;
        res_lt = 1'b0;
        reset = 1'b0;
        follow(16'hC000, 16'h4000, 1'b0, 0);
        check_idle();
    endtask

    task automatic test_back_to_back();
        launch(16'h4000, 16'h8000);
        for (int n = 0; n < 4; n++)
            follow(16'h4000, 16'h8000, 1'b1, 0);
        check_idle();
    endtask

    // Random operands with a random shared prefix so every latency 1..NCHUNK is exercised.
    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           cut;
        bit           chain;
        chain = 1'b0;
        for (int n = 0; n < 60; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            cut = $urandom_range(0, W);
            for (int i = W - 1; i >= cut; i--) rb[i] = ra[i];
            if (!chain) begin
                @(negedge clk);
            end
            launch(ra, rb);
            follow(ra, rb, 1'b0, (n % 5 == 2) ? 1 : 0);
            chain = ($urandom_range(0, 1) == 1);
            if (!chain) check_idle();
        end
        check_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_abort();
        test_reset_with_start();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
